// File: rtl/fetch_ctrl.sv
// Fetch sequencing controller: owns the fetch PC, issues one aligned 8-byte request at a time,
// and buffers the returned word for the fetch result stage. Optional counters: FETCH_CTRL_PERF_EN.
`timescale 1ns/1ps
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_i_redirect_valid,
  input  logic [63:0] io_i_redirect_target,
  input  logic        io_i_predict_taken,
  input  logic [63:0] io_i_predict_target,
  output logic        io_o_req_valid,
  output logic [63:0] io_o_req_addr,
  input  logic        io_i_req_ready,
  input  logic        io_i_resp_valid,
  input  logic [63:0] io_i_resp_data,
  output logic        io_o_fetch_valid,
  output logic [63:0] io_o_fetch_pc,
  output logic [63:0] io_o_fetch_data,
  input  logic        io_i_fetch_ready,
  output logic        io_o_busy
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] io_o_perf_pkt_cnt,
  output logic [31:0] io_o_perf_kill_cnt
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_KILL} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] data_q, data_d;
  logic [63:0] seq_pc;
  logic        handoff;
  logic        drop;

  assign seq_pc = {pc_q[63:3] + 61'd1, 3'b000};

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    data_d  = data_q;
    handoff = 1'b0;
    drop    = 1'b0;
    case (state_q)
      S_REQ: begin
        if (io_i_redirect_valid)  pc_d = io_i_redirect_target;
        else if (io_i_req_ready)  state_d = S_WAIT;
      end
      S_WAIT: begin
        if (io_i_resp_valid && io_i_redirect_valid) begin
          drop    = 1'b1;
          pc_d    = io_i_redirect_target;
          state_d = S_REQ;
        end else if (io_i_resp_valid) begin
          data_d  = io_i_resp_data;
          state_d = S_HOLD;
        end else if (io_i_redirect_valid) begin
          pc_d    = io_i_redirect_target;
          state_d = S_KILL;
        end
      end
      S_KILL: begin
        // The stale response still has to drain before a new request may be issued.
        if (io_i_redirect_valid) pc_d = io_i_redirect_target;
        if (io_i_resp_valid) begin
          drop    = 1'b1;
          state_d = S_REQ;
        end
      end
      S_HOLD: begin
        if (io_i_redirect_valid) begin
          pc_d    = io_i_redirect_target;
          state_d = S_REQ;
        end else if (io_i_fetch_ready) begin
          handoff = 1'b1;
          pc_d    = io_i_predict_taken ? io_i_predict_target : seq_pc;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      data_q  <= 64'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
    end
  end

  // A redirect suppresses both the request and the packet in the cycle it arrives.
  assign io_o_req_valid   = (state_q == S_REQ) && !io_i_redirect_valid && !reset;
  assign io_o_req_addr    = {pc_q[63:3], 3'b000};
  assign io_o_fetch_valid = (state_q == S_HOLD) && !io_i_redirect_valid;
  assign io_o_fetch_pc    = pc_q;
  assign io_o_fetch_data  = data_q;
  assign io_o_busy        = (state_q == S_WAIT) || (state_q == S_KILL);

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] kill_cnt_q, kill_cnt_d;

  always_comb begin
    pkt_cnt_d  = pkt_cnt_q + {31'd0, handoff};
    kill_cnt_d = kill_cnt_q + {31'd0, drop};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pkt_cnt_q  <= 32'd0;
      kill_cnt_q <= 32'd0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      kill_cnt_q <= kill_cnt_d;
    end
  end

  assign io_o_perf_pkt_cnt  = pkt_cnt_q;
  assign io_o_perf_kill_cnt = kill_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a transaction-level model (outstanding / stale / packet flags).
`timescale 1ns/1ps
module tb_fetch_ctrl;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_i_redirect_valid = 1'b0;
  logic [63:0] io_i_redirect_target = '0;
  logic        io_i_predict_taken = 1'b0;
  logic [63:0] io_i_predict_target = '0;
  logic        io_o_req_valid;
  logic [63:0] io_o_req_addr;
  logic        io_i_req_ready = 1'b0;
  logic        io_i_resp_valid = 1'b0;
  logic [63:0] io_i_resp_data = '0;
  logic        io_o_fetch_valid;
  logic [63:0] io_o_fetch_pc;
  logic [63:0] io_o_fetch_data;
  logic        io_i_fetch_ready = 1'b0;
  logic        io_o_busy;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] io_o_perf_pkt_cnt;
  logic [31:0] io_o_perf_kill_cnt;
`endif

  fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clock               (clock),
    .reset               (reset),
    .io_i_redirect_valid (io_i_redirect_valid),
    .io_i_redirect_target(io_i_redirect_target),
    .io_i_predict_taken  (io_i_predict_taken),
    .io_i_predict_target (io_i_predict_target),
    .io_o_req_valid      (io_o_req_valid),
    .io_o_req_addr       (io_o_req_addr),
    .io_i_req_ready      (io_i_req_ready),
    .io_i_resp_valid     (io_i_resp_valid),
    .io_i_resp_data      (io_i_resp_data),
    .io_o_fetch_valid    (io_o_fetch_valid),
    .io_o_fetch_pc       (io_o_fetch_pc),
    .io_o_fetch_data     (io_o_fetch_data),
    .io_i_fetch_ready    (io_i_fetch_ready),
    .io_o_busy           (io_o_busy)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .io_o_perf_pkt_cnt   (io_o_perf_pkt_cnt),
    .io_o_perf_kill_cnt  (io_o_perf_kill_cnt)
`endif
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a request is outstanding, possibly stale, or a packet is held.
  logic [63:0] m_pc;
  logic        m_out, m_stale, m_pkt;
  logic [63:0] m_data;
  logic [31:0] m_pkt_cnt, m_kill_cnt;
  logic        e_rv, e_fv;
  logic        acc_last = 1'b0;

  always @(negedge clock) begin
    if (reset) begin
      check("rst_req_valid",   io_o_req_valid,   64'd0);
      check("rst_req_addr",    io_o_req_addr,    RESET_PC & ~64'd7);
      check("rst_fetch_valid", io_o_fetch_valid, 64'd0);
      check("rst_fetch_pc",    io_o_fetch_pc,    RESET_PC);
      check("rst_fetch_data",  io_o_fetch_data,  64'd0);
      check("rst_busy",        io_o_busy,        64'd0);
`ifdef FETCH_CTRL_PERF_EN
      check("rst_pkt_cnt",  {32'd0, io_o_perf_pkt_cnt},  64'd0);
      check("rst_kill_cnt", {32'd0, io_o_perf_kill_cnt}, 64'd0);
`endif
      m_pc = RESET_PC; m_out = 1'b0; m_stale = 1'b0; m_pkt = 1'b0; m_data = '0;
      m_pkt_cnt = '0; m_kill_cnt = '0; acc_last = 1'b0;
    end else begin
      e_rv = !m_out && !m_pkt && !io_i_redirect_valid;
      e_fv = m_pkt && !io_i_redirect_valid;
      check("req_valid",   io_o_req_valid,   e_rv);
      check("req_addr",    io_o_req_addr,    (m_pc >> 3) << 3);
      check("busy",        io_o_busy,        m_out);
      check("fetch_valid", io_o_fetch_valid, e_fv);
      check("fetch_pc",    io_o_fetch_pc,    m_pc);
      if (e_fv) check("fetch_data", io_o_fetch_data, m_data);
`ifdef FETCH_CTRL_PERF_EN
      check("pkt_cnt",  {32'd0, io_o_perf_pkt_cnt},  {32'd0, m_pkt_cnt});
      check("kill_cnt", {32'd0, io_o_perf_kill_cnt}, {32'd0, m_kill_cnt});
`endif
      acc_last = e_rv && io_i_req_ready;
      if (m_out) begin
        if (io_i_resp_valid) begin
          if (m_stale || io_i_redirect_valid) m_kill_cnt = m_kill_cnt + 1;
          else begin m_data = io_i_resp_data; m_pkt = 1'b1; end
          m_out = 1'b0; m_stale = 1'b0;
          if (io_i_redirect_valid) m_pc = io_i_redirect_target;
        end else if (io_i_redirect_valid) begin
          m_pc = io_i_redirect_target; m_stale = 1'b1;
        end
      end else if (m_pkt) begin
        if (io_i_redirect_valid) begin
          m_pc = io_i_redirect_target; m_pkt = 1'b0;
        end else if (io_i_fetch_ready) begin
          m_pkt_cnt = m_pkt_cnt + 1;
          m_pc  = io_i_predict_taken ? io_i_predict_target : ((m_pc >> 3) + 64'd1) << 3;
          m_pkt = 1'b0;
        end
      end else begin
        if (io_i_redirect_valid) m_pc = io_i_redirect_target;
        else if (io_i_req_ready) begin m_out = 1'b1; m_stale = 1'b0; end
      end
    end
  end

  // Advance to the next cycle and drop all single-cycle pulses.
  task automatic tick();
    @(posedge clock); #1;
    io_i_resp_valid     = 1'b0;
    io_i_redirect_valid = 1'b0;
    io_i_predict_taken  = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    io_i_redirect_valid = 1'b0; io_i_predict_taken = 1'b0; io_i_req_ready = 1'b0;
    io_i_resp_valid = 1'b0; io_i_fetch_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  function automatic logic [63:0] rand_pc();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return {$urandom, $urandom};
    if (sel == 1) return 64'hFFFF_FFFF_FFFF_FFF8 | 64'($urandom_range(0, 7));
    return 64'h8000_0000 | 64'($urandom_range(0, 32'hFFFF));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pending;
    int wcnt;

    // PC wrap from the top of the address space
    do_reset();
    io_i_redirect_valid = 1'b1; io_i_redirect_target = 64'hFFFF_FFFF_FFFF_FFF8;
    @(negedge clock); check("wrap_redir_req_valid", io_o_req_valid, 64'd0);
    tick(); io_i_req_ready = 1'b1;
    @(negedge clock); check("wrap_req_addr", io_o_req_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    tick(); io_i_req_ready = 1'b0; io_i_resp_valid = 1'b1; io_i_resp_data = 64'h1234_5678_9ABC_DEF0;
    @(negedge clock); check("wrap_busy", io_o_busy, 64'd1);
    tick(); io_i_fetch_ready = 1'b1;
    @(negedge clock); check("wrap_fetch_pc", io_o_fetch_pc, 64'hFFFF_FFFF_FFFF_FFF8);
    check("wrap_fetch_data", io_o_fetch_data, 64'h1234_5678_9ABC_DEF0);
    tick(); io_i_fetch_ready = 1'b0;
    @(negedge clock); check("wrap_next_addr", io_o_req_addr, 64'd0);
    check("wrap_next_valid", io_o_req_valid, 64'd1);
`ifdef FETCH_CTRL_PERF_EN
    check("wrap_pkt_cnt",  {32'd0, io_o_perf_pkt_cnt},  64'd1);
    check("wrap_kill_cnt", {32'd0, io_o_perf_kill_cnt}, 64'd0);
`endif

    // Basic fetch, redirect in HOLD, predicted-taken handoff, redirects in WAIT
    do_reset();
    io_i_req_ready = 1'b1;
    @(negedge clock); check("t1_req_valid", io_o_req_valid, 64'd1);
    check("t1_req_addr", io_o_req_addr, 64'h8000_0000);
    tick(); io_i_req_ready = 1'b0; io_i_resp_valid = 1'b1; io_i_resp_data = 64'hDEAD_BEEF_0000_0013;
    @(negedge clock); check("t1_busy", io_o_busy, 64'd1);
    tick(); io_i_fetch_ready = 1'b1;
    @(negedge clock); check("t1_fetch_valid", io_o_fetch_valid, 64'd1);
    check("t1_fetch_pc", io_o_fetch_pc, 64'h8000_0000);
    check("t1_fetch_data", io_o_fetch_data, 64'hDEAD_BEEF_0000_0013);
    tick(); io_i_fetch_ready = 1'b0; io_i_req_ready = 1'b1;
    @(negedge clock); check("t1_seq_addr", io_o_req_addr, 64'h8000_0008);
    tick(); io_i_req_ready = 1'b0; io_i_resp_valid = 1'b1; io_i_resp_data = 64'h0000_0001_0000_0002;
    tick(); io_i_fetch_ready = 1'b1; io_i_redirect_valid = 1'b1; io_i_redirect_target = 64'h8000_0104;
    @(negedge clock); check("t2_hold_redir_fv", io_o_fetch_valid, 64'd0);
    tick(); io_i_fetch_ready = 1'b0; io_i_req_ready = 1'b1;
    @(negedge clock); check("t2_req_addr", io_o_req_addr, 64'h8000_0100);
    tick(); io_i_req_ready = 1'b0; io_i_resp_valid = 1'b1; io_i_resp_data = 64'h0000_0003_0000_0004;
    tick(); io_i_fetch_ready = 1'b1; io_i_predict_taken = 1'b1; io_i_predict_target = 64'h8000_2004;
    @(negedge clock); check("t2_fetch_pc", io_o_fetch_pc, 64'h8000_0104);
    check("t2_fetch_valid", io_o_fetch_valid, 64'd1);
    tick(); io_i_fetch_ready = 1'b0; io_i_req_ready = 1'b1;
    @(negedge clock); check("t5_pred_addr", io_o_req_addr, 64'h8000_2000);
    check("t5_pred_pc", io_o_fetch_pc, 64'h8000_2004);
    tick(); io_i_req_ready = 1'b0; io_i_redirect_valid = 1'b1; io_i_redirect_target = 64'h8000_1000;
    @(negedge clock); check("t3_busy_redir", io_o_busy, 64'd1);
    tick();
    @(negedge clock); check("t3_busy_kill1", io_o_busy, 64'd1);
    check("t3_no_req", io_o_req_valid, 64'd0);
    tick();
    @(negedge clock); check("t3_busy_kill2", io_o_busy, 64'd1);
    tick(); io_i_resp_valid = 1'b1; io_i_resp_data = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clock); check("t3_busy_stale", io_o_busy, 64'd1);
    tick(); io_i_req_ready = 1'b1;
    @(negedge clock); check("t3_busy_clear", io_o_busy, 64'd0);
    check("t3_req_addr", io_o_req_addr, 64'h8000_1000);
    check("t3_no_packet", io_o_fetch_valid, 64'd0);
    tick(); io_i_req_ready = 1'b0; io_i_redirect_valid = 1'b1; io_i_redirect_target = 64'h8000_3008;
    io_i_resp_valid = 1'b1; io_i_resp_data = 64'hBAD1_BAD1_BAD1_BAD1;
    @(negedge clock); check("t4_fv", io_o_fetch_valid, 64'd0);
    tick();
    @(negedge clock); check("t4_req_valid", io_o_req_valid, 64'd1);
    check("t4_req_addr", io_o_req_addr, 64'h8000_3008);
    check("t4_no_packet", io_o_fetch_valid, 64'd0);
    check("t4_model_pc", m_pc, 64'h8000_3008);
`ifdef FETCH_CTRL_PERF_EN
    check("t4_pkt_cnt",  {32'd0, io_o_perf_pkt_cnt},  64'd2);
    check("t4_kill_cnt", {32'd0, io_o_perf_kill_cnt}, 64'd2);
`endif

    // Randomized traffic with a single-outstanding memory responder
    do_reset();
    pending = 0;
    wcnt    = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc != 0) tick();
      if (acc_last) begin
        pending = 1;
        wcnt    = $urandom_range(0, 3);
      end
      io_i_resp_data = {$urandom, $urandom};
      if (pending != 0) begin
        if (wcnt == 0) begin
          io_i_resp_valid = 1'b1;
          pending = 0;
        end else begin
          wcnt--;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        io_i_resp_valid = 1'b1;
      end
      io_i_redirect_valid  = ($urandom_range(0, 7) == 0);
      io_i_redirect_target = rand_pc();
      io_i_req_ready       = $urandom_range(0, 1) != 0;
      io_i_fetch_ready     = $urandom_range(0, 2) != 0;
      io_i_predict_taken   = $urandom_range(0, 2) == 0;
      io_i_predict_target  = rand_pc();
    end
    tick();
    io_i_req_ready = 1'b0; io_i_fetch_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
